// File: rtl/test_ctrl_pkg.sv
// Shared definitions for test_ctrl: register offsets, STATUS bit layout
// and the bus FSM state type.
package test_ctrl_pkg;

    // Byte offsets of the four word registers (addr bits [1:0] are ignored)
    localparam logic [3:0] REG_TOHOST  = 4'h0;
    localparam logic [3:0] REG_CYCLE   = 4'h4;
    localparam logic [3:0] REG_CONSOLE = 4'h8;
    localparam logic [3:0] REG_STATUS  = 4'hC;

    // STATUS register bit positions
    localparam int unsigned ST_DONE      = 0;
    localparam int unsigned ST_PASS      = 1;
    localparam int unsigned ST_FAIL      = 2;
    localparam int unsigned ST_TIMEOUT   = 3;
    localparam int unsigned ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP      = 2'd1,
        WAIT_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/test_ctrl_fifo.sv
// Console byte FIFO for test_ctrl. DEPTH must be a power of two (>= 2);
// pointers wrap naturally. pop_data reads 0 while the FIFO is empty.
module test_ctrl_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rptr];

    // Storage write; contents need no reset since empty masks the output
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/test_ctrl.sv
// test_ctrl: simulation test-status peripheral (TOHOST / CYCLE / CONSOLE /
// STATUS registers) with a one-cycle-latency request/ready bus.
// Optional feature: define TEST_CTRL_CONSOLE_EN to build the console FIFO;
// without it CONSOLE writes are discarded and the console port stays idle.
module test_ctrl
    import test_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [30:0] fail_code_o,
    output logic        timeout_o,
    output logic [31:0] cycle_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i
);
    localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t         state;
    state_t         state_next;
    logic [3:0]     offset;
    logic [31:0]    rdata;
    logic [31:0]    read_value;
    logic [31:0]    status;
    logic           tohost_wr;
    logic           set_done;
    logic           set_timeout;
    logic           fifo_push;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    logic [1:0]     unused_addr_lsb;

    assign offset          = {addr_i[3:2], 2'b00};
    assign unused_addr_lsb = addr_i[1:0];
    assign rdata_o         = rdata;
    // A reset arriving during RESP suppresses the completion pulse
    assign ready_o         = (state == RESP) && !rst;

    assign set_done    = tohost_wr && !done_o;
    assign set_timeout = !done_o && !timeout_o && !tohost_wr && (cycle_o == TIMEOUT_LAST);

    // Bus FSM next state; side effects fire on the accepting edge
    always_comb begin
        state_next = state;
        tohost_wr  = 1'b0;
        fifo_push  = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (we_i && (offset == REG_CONSOLE) && fifo_full) begin
                        state_next = WAIT_FULL;
                    end else begin
                        state_next = RESP;
                        tohost_wr  = we_i && (offset == REG_TOHOST);
                        fifo_push  = we_i && (offset == REG_CONSOLE);
                    end
                end
            end
            WAIT_FULL: begin
                if (!fifo_full) begin
                    state_next = RESP;
                    fifo_push  = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // STATUS word and read mux
    always_comb begin
        status                      = '0;
        status[31:ST_COUNT_LSB]     = (32 - ST_COUNT_LSB)'(fifo_count);
        status[ST_TIMEOUT]          = timeout_o;
        status[ST_FAIL]             = done_o && !pass_o;
        status[ST_PASS]             = pass_o;
        status[ST_DONE]             = done_o;
        case (offset)
            REG_CYCLE:  read_value = cycle_o;
            REG_STATUS: read_value = status;
            default:    read_value = '0;
        endcase
    end

    // State register and response data (held only for the RESP cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdata <= '0;
        end else begin
            state <= state_next;
            rdata <= ((state == IDLE) && req_i && !we_i) ? read_value : '0;
        end
    end

    // Sticky test result, timeout flag and freezing saturating cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_code_o <= '0;
            timeout_o   <= 1'b0;
            cycle_o     <= '0;
        end else begin
            if (set_done) begin
                done_o      <= 1'b1;
                pass_o      <= (wdata_i == 32'd1);
                fail_code_o <= wdata_i[31:1];
            end
            if (set_timeout) begin
                timeout_o <= 1'b1;
            end
            if (!done_o && !timeout_o && !set_done && !set_timeout && (cycle_o != '1)) begin
                cycle_o <= cycle_o + 32'd1;
            end
        end
    end

`ifdef TEST_CTRL_CONSOLE_EN
    logic fifo_empty;

    test_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wdata_i[7:0]),
        .pop       (con_ready_i),
        .pop_data  (con_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign con_valid_o = !fifo_empty;
`else
    logic unused_console;

    assign fifo_full      = 1'b0;
    assign fifo_count     = '0;
    assign con_valid_o    = 1'b0;
    assign con_data_o     = '0;
    assign unused_console = con_ready_i ^ fifo_push;
`endif

endmodule

// File: doc/test_ctrl.md
TEST_CTRL -- requirements
Module: test_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000, meaning cycles after reset before the timeout flag is set.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning console FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  1  bus request; held by the core until ready_o.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  4  byte offset; bits[1:0] ignored.
REQ-008 SHALL have port wdata_i  input  32  write data.
REQ-009 SHALL have port rdata_o  output  32  read data, valid while ready_o=1.
REQ-010 SHALL have port ready_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports done_o 1, pass_o 1, fail_code_o 31, timeout_o 1, cycle_o 32, all outputs: test status.
REQ-012 SHALL have ports con_valid_o output 1, con_data_o output 8, con_ready_i input 1: console byte stream.

Function
REQ-013 Register map SHALL be: 0x0 TOHOST (WO), 0x4 CYCLE (RO), 0x8 CONSOLE (WO), 0xC STATUS (RO); reads of WO registers return 0; writes to RO registers complete with no effect.
REQ-014 Bus FSM SHALL have states IDLE, RESP, WAIT_FULL: IDLE with req_i -> RESP (or WAIT_FULL for a CONSOLE write with FIFO full); RESP drives ready_o=1 for exactly one cycle -> IDLE; WAIT_FULL -> RESP in the cycle after FIFO space appears.
REQ-015 Latency SHALL be one cycle from accepted req_i to ready_o; a back-to-back request is accepted in the IDLE cycle that follows RESP.
REQ-016 A TOHOST write with done_o=0 SHALL set done_o=1; pass_o=1 iff wdata_i==1; otherwise fail_code_o=wdata_i[31:1].
REQ-017 done_o, pass_o and fail_code_o SHALL be sticky; later TOHOST writes complete but are ignored.
REQ-018 The cycle counter (cycle_o) SHALL increment every cycle, freeze when done_o or timeout_o is set, and saturate at 0xFFFFFFFF.
REQ-019 timeout_o SHALL set, sticky, when cycle_o==TIMEOUT_CYCLES-1 and done_o=0; if the TOHOST write lands in that same cycle, done wins and timeout_o stays 0.
REQ-020 A CONSOLE write SHALL push wdata_i[7:0]; con_valid_o=1 while the FIFO is non-empty; pop on con_valid_o & con_ready_i.
REQ-021 Simultaneous push and pop on a full FIFO SHALL be stalled (WAIT_FULL) and then accepted the following cycle; simultaneous push and pop when non-full SHALL leave the count unchanged.
REQ-022 STATUS SHALL read {count[31:8], 4'b0, timeout, fail, pass, done}, where fail = done & ~pass.

Reset
REQ-023 With rst=1 at a clock edge: FSM=IDLE, ready_o=0, rdata_o=0, done_o=0, pass_o=0, fail_code_o=0, timeout_o=0, cycle_o=0, FIFO empty, con_valid_o=0, con_data_o=0.
REQ-024 Reset asserted mid-transaction SHALL abort it with no ready_o pulse; the core must re-issue the request.

Configuration
REQ-025 With macro TEST_CTRL_CONSOLE_EN defined: the FIFO and console behaviour SHALL be as above.
REQ-026 With TEST_CTRL_CONSOLE_EN undefined: there SHALL be no FIFO; CONSOLE writes complete in one cycle and are discarded; con_valid_o=0 and con_data_o=0; the STATUS count field reads 0; WAIT_FULL is unreachable.

Structure
REQ-027 Package test_ctrl_pkg SHALL hold the register offset constants, the STATUS bit positions and the FSM state typedef.
REQ-028 The console FIFO SHALL be sub-module test_ctrl_fifo (parameter DEPTH, WIDTH=8; push/pop/full/empty/count), instantiated only under TEST_CTRL_CONSOLE_EN.

Verification
REQ-029 Write TOHOST=0x1 -> ready_o one cycle later; done_o=1, pass_o=1, cycle_o frozen; a later write of 0x7 leaves pass_o=1.
REQ-030 Write TOHOST=0x7 -> done_o=1, pass_o=0, fail_code_o=3; STATUS read returns 0x...5 in bits[3:0].
REQ-031 No TOHOST write, TIMEOUT_CYCLES=20 -> timeout_o=1 when cycle_o=19, cycle_o then holds 19; TOHOST write landing at cycle 19 -> done_o=1, timeout_o=0.
REQ-032 con_ready_i=0, five CONSOLE writes 'A'..'E' with FIFO_DEPTH=4 -> the fifth stalls in WAIT_FULL; releasing con_ready_i drains 'A','B','C','D','E' in order and the fifth write completes.
REQ-033 rst pulsed while a request is in RESP/WAIT_FULL -> no ready_o pulse; every output returns to its reset value the next cycle.
REQ-034 Build without TEST_CTRL_CONSOLE_EN: CONSOLE write completes in 1 cycle; con_valid_o stays 0; STATUS bits[31:8]=0.
